// File: rtl/wr_ptr_full_ctrl_pkg.sv
// Shared async-FIFO pointer types and Gray/binary conversion helpers.
// Used by both the write-side full controller and the read-side empty controller.
// Pure combinational helpers; no state.
package fifo_pkg;

  localparam int FIFO_AW = 9;

  typedef logic [FIFO_AW:0] ptr_t;

  // Generic 32-bit conversions; callers zero-extend/truncate to pointer width.
  // Leading zeros in a Gray value decode to leading zeros in binary, so the
  // truncated result is exact for any narrower pointer.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wr_ptr_full_ctrl_if.sv
// Write-domain bus of the async FIFO: producer request, remote read pointer in,
// RAM write strobe/address, exported Gray write pointer and status flags out.
// master = producer/read-domain side, slave = wr_ptr_full_ctrl.
interface wr_ptr_full_ctrl_if
  import fifo_pkg::*;
#(
  parameter int Addr_Width = FIFO_AW
);

  logic                  winc;
  logic [Addr_Width:0]   rptr;
  logic                  wen;
  logic [Addr_Width-1:0] waddr;
  logic [Addr_Width:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [Addr_Width:0]   wlevel;
  logic                  woverflow;

  modport master (
    output winc, rptr,
    input  wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, rptr,
    output wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

endinterface

// File: rtl/wr_ptr_full_ctrl_rd_2_wr_sync.sv
// Two-flop synchroniser bringing the Gray read pointer into the write clock.
// Ports: clk/rst (async active-high), i_d (async Gray input), o_q (synchronised).
// Latency: a stable input change appears on o_q after the 2nd clk edge.
module rd_2_wr_sync
  import fifo_pkg::*;
#(
  parameter int Width = FIFO_AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_q1;
  logic [Width-1:0] r_q2;

  // Input is Gray-coded, so at most one bit can be mid-transition per sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// Write-domain pointer/full controller of the async FIFO: binary+Gray write
// pointer, RAM write address/strobe, full, almost-full, level, sticky overflow.
// Ports: wclk, wrst (async active-high), bus (slave): winc, rptr in; wen,
// waddr, wptr, wfull, walmost_full, wlevel, woverflow out. wen is combinational,
// everything else registered. Flags release 3 wclk edges after a read pointer move.
module wr_ptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int Addr_Width = FIFO_AW,
  parameter int AF_Margin  = 4
) (
  input  logic          wclk,
  input  logic          wrst,
  wr_ptr_full_ctrl_if.slave bus
);

  localparam int                  Depth    = 1 << Addr_Width;
  localparam logic [Addr_Width:0] AfThresh = (Addr_Width + 1)'(Depth - AF_Margin);

  logic [Addr_Width:0] r_wbin;
  logic [Addr_Width:0] r_wptr;
  logic [Addr_Width:0] r_wlevel;
  logic                r_wfull;
  logic                r_walmost_full;
  logic                r_woverflow;

  logic                w_wen;
  logic [Addr_Width:0] w_rptr_s;
  logic [Addr_Width:0] w_rbin_s;
  logic [Addr_Width:0] w_wbin_next;
  logic [Addr_Width:0] w_wgray_next;
  logic [Addr_Width:0] w_full_gray;
  logic [Addr_Width:0] w_level_next;

  rd_2_wr_sync #(
    .Width(Addr_Width + 1)
  ) u_rptr_sync (
    .clk (wclk),
    .rst (wrst),
    .i_d (bus.rptr),
    .o_q (w_rptr_s)
  );

  assign w_wen        = bus.winc & ~r_wfull;
  assign w_wbin_next  = r_wbin + (Addr_Width + 1)'(w_wen);
  assign w_wgray_next = (Addr_Width + 1)'(bin2gray(32'(w_wbin_next)));
  assign w_rbin_s     = (Addr_Width + 1)'(gray2bin(32'(w_rptr_s)));

  // Full when the write pointer is exactly one lap ahead: in Gray that is the
  // synchronised read pointer with its two MSBs inverted.
  assign w_full_gray  = {~w_rptr_s[Addr_Width:Addr_Width-1], w_rptr_s[Addr_Width-2:0]};

  // Modular difference; a stale read pointer only makes this larger, never smaller.
  assign w_level_next = w_wbin_next - w_rbin_s;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wptr         <= w_wgray_next;
      r_wfull        <= (w_wgray_next == w_full_gray);
      r_walmost_full <= (w_level_next >= AfThresh);
      r_wlevel       <= w_level_next;
      r_woverflow    <= r_woverflow | (bus.winc & r_wfull);
    end
  end

  assign bus.wen          = w_wen;
  assign bus.waddr        = r_wbin[Addr_Width-1:0];
  assign bus.wptr         = r_wptr;
  assign bus.wfull        = r_wfull;
  assign bus.walmost_full = r_walmost_full;
  assign bus.wlevel       = r_wlevel;
  assign bus.woverflow    = r_woverflow;

endmodule
